// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle NPC sequencer.
// Holds the state encoding, trap cause codes, reset PC and NOP word.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    TRAP
  } state_t;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd2;
  localparam logic [2:0] CAUSE_IFU_ERR  = 3'd3;
  localparam logic [2:0] CAUSE_LSU_ERR  = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT  = 3'd5;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/core_watchdog.sv
// Response watchdog: counts consecutive enabled cycles, raises expired
// on the TIMEOUT-th one. Ports: clk, rst, clr, en in; expired out.
module core_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of earlier wait cycles, so this is the
  // TIMEOUT-th consecutive one
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_seq.sv
// Handshaked fetch/exec/mem/write-back sequencer owning pc, inst, counters
// and a sticky trap. Ports: IFU req/resp, IDU/EXU decode, LSU req/resp, status.
module core_seq
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              CNT_W    = 64,
  parameter int              TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_resp_valid,
  input  logic             ifu_resp_err,
  input  logic [31:0]      ifu_resp_inst,
  input  logic             dec_mem,
  input  logic             dec_rd_wen,
  input  logic [4:0]       dec_rd,
  input  logic             dec_illegal,
  input  logic [XLEN-1:0]  exu_next_pc,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  input  logic             lsu_resp_err,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      inst,
  output logic             rf_wen,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             trap,
  output logic [2:0]       trap_cause
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cause_nxt;
  logic       load_inst;
  logic       in_wait;
  logic       wd_expired;

  assign in_wait = (state == FETCH_WAIT) || (state == MEM_WAIT);

  core_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_NONE;
    load_inst = 1'b0;
    unique case (state)
      FETCH_REQ: begin
        if (ifu_req_ready) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // expiry wins over a response landing in the same cycle
        if (wd_expired) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end else if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_nxt = TRAP;
            cause_nxt = CAUSE_IFU_ERR;
          end else begin
            state_nxt = EXEC;
            load_inst = 1'b1;
          end
        end
      end
      EXEC: begin
        if (dec_illegal) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else if (exu_next_pc[1:0] != 2'b00) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_MISALIGN;
        end else if (dec_mem) begin
          state_nxt = MEM_REQ;
        end else begin
          state_nxt = WB;
        end
      end
      MEM_REQ: begin
        if (lsu_req_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (wd_expired) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end else if (lsu_resp_valid) begin
          if (lsu_resp_err) begin
            state_nxt = TRAP;
            cause_nxt = CAUSE_LSU_ERR;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB:      state_nxt = FETCH_REQ;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_REQ;
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      trap_cause  <= CAUSE_NONE;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (load_inst) inst <= ifu_resp_inst;
      if (state == WB) begin
        pc          <= exu_next_pc;
        instret_cnt <= instret_cnt + CNT_ONE;
      end
      if (state != TRAP && state_nxt == TRAP) begin
        trap_cause <= cause_nxt;
      end
    end
  end

  assign ifu_req_valid = (state == FETCH_REQ);
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = (state == MEM_REQ);
  assign retire        = (state == WB);
  assign rf_wen        = retire && dec_rd_wen && (dec_rd != 5'd0);
  assign trap          = (state == TRAP);

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: per-scenario cycle schedules built from
// instruction latencies, checked every cycle plus literal pins.
module tb_core_seq;
  import core_pkg::*;

  localparam int          TO   = 8;
  localparam int          MAXC = 64;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_resp_inst;
  logic        dec_mem, dec_rd_wen, dec_illegal;
  logic [4:0]  dec_rd;
  logic [31:0] exu_next_pc;
  logic        lsu_req_valid, lsu_req_ready;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] pc, inst;
  logic        rf_wen, retire, trap;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [2:0]  trap_cause;

  always #5 clk = ~clk;

  core_seq #(
    .XLEN(32), .RESET_PC(RPC), .CNT_W(64), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_err(ifu_resp_err), .ifu_resp_inst(ifu_resp_inst),
    .dec_mem(dec_mem), .dec_rd_wen(dec_rd_wen), .dec_rd(dec_rd),
    .dec_illegal(dec_illegal), .exu_next_pc(exu_next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err),
    .pc(pc), .inst(inst), .rf_wen(rf_wen), .retire(retire),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .trap(trap), .trap_cause(trap_cause)
  );

  // stimulus schedule
  bit          d_irdy[MAXC], d_irv[MAXC], d_ierr[MAXC];
  bit          d_lrdy[MAXC], d_lrv[MAXC], d_lerr[MAXC];
  bit          d_mem[MAXC], d_wen[MAXC], d_ill[MAXC];
  logic [4:0]  d_rd[MAXC];
  logic [31:0] d_word[MAXC], d_npc[MAXC];
  // expected per-cycle outputs
  bit          e_iv[MAXC], e_lv[MAXC], e_ret[MAXC], e_wen[MAXC], e_trap[MAXC];
  logic [31:0] e_pc[MAXC], e_inst[MAXC];
  logic [63:0] e_icnt[MAXC];
  logic [2:0]  e_cause[MAXC];
  // architectural model state
  logic [31:0] mpc, minst;
  logic [63:0] mret;
  bit          mtrap, trapped;
  logic [2:0]  mcause;
  int          cur, filled, endc;

  int n_chk, n_fail;
  bit chk_en;
  int cc, first_ret, first_trap;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ifu_req_valid", 64'(ifu_req_valid), 64'(e_iv[cc]));
      chk("lsu_req_valid", 64'(lsu_req_valid), 64'(e_lv[cc]));
      chk("retire", 64'(retire), 64'(e_ret[cc]));
      chk("rf_wen", 64'(rf_wen), 64'(e_wen[cc]));
      chk("pc", 64'(pc), 64'(e_pc[cc]));
      chk("inst", 64'(inst), 64'(e_inst[cc]));
      chk("instret_cnt", instret_cnt, e_icnt[cc]);
      chk("cycle_cnt", cycle_cnt, 64'(cc));
      chk("trap", 64'(trap), 64'(e_trap[cc]));
      chk("trap_cause", 64'(trap_cause), 64'(e_cause[cc]));
      if (e_iv[cc]) chk("ifu_req_addr", 64'(ifu_req_addr), 64'(e_pc[cc]));
      if (retire && first_ret < 0) first_ret = cc;
      if (trap && first_trap < 0) first_trap = cc;
    end
  end

  task automatic clr();
    for (int c = 0; c < MAXC; c++) begin
      d_irdy[c] = 0; d_irv[c] = 0; d_ierr[c] = 0;
      d_lrdy[c] = 0; d_lrv[c] = 0; d_lerr[c] = 0;
      d_mem[c] = 0; d_wen[c] = 0; d_ill[c] = 0;
      d_rd[c] = '0; d_word[c] = '0; d_npc[c] = '0;
      e_iv[c] = 0; e_lv[c] = 0; e_ret[c] = 0; e_wen[c] = 0;
    end
    mpc = RPC; minst = NOP; mret = '0; mtrap = 0; mcause = 3'd0;
    trapped = 0; cur = 0; filled = 0; endc = 0;
  endtask

  // model state holds for cycles [filled, to)
  task automatic adv(input int to);
    for (int c = filled; c < to && c < MAXC; c++) begin
      e_pc[c] = mpc; e_inst[c] = minst; e_icnt[c] = mret;
      e_trap[c] = mtrap; e_cause[c] = mcause;
    end
    filled = to;
  endtask

  task automatic trap_at(input int t, input logic [2:0] cause);
    adv(t);
    mtrap = 1; mcause = cause; trapped = 1; endc = t + 3;
  endtask

  task automatic add_inst(input int ird, input int irsp,
      input logic [31:0] w, input bit mem, input int lrd, input int lrsp,
      input bit wen, input logic [4:0] rd, input logic [31:0] npc,
      input bit ill, input bit ierr, input bit lerr);
    int s, f, x, m, wt, wb;
    s = cur;
    for (int c = s; c < MAXC; c++) begin
      d_mem[c] = mem; d_wen[c] = wen; d_rd[c] = rd;
      d_ill[c] = ill; d_npc[c] = npc;
    end
    for (int i = 0; i <= ird; i++) e_iv[s+i] = 1;
    d_irdy[s+ird] = 1;
    f = s + ird + 1;
    if (irsp != 0) begin
      d_irv[f+irsp-1] = 1; d_ierr[f+irsp-1] = ierr;
      d_word[f+irsp-1] = w;
    end
    if (irsp == 0 || irsp >= TO) begin
      trap_at(f + TO, 3'd5); return;
    end
    x = f + irsp;
    if (ierr) begin
      trap_at(x, 3'd3); return;
    end
    adv(x);
    minst = w;
    if (ill) begin
      trap_at(x + 1, 3'd1); return;
    end
    if (npc[1:0] != 2'b00) begin
      trap_at(x + 1, 3'd2); return;
    end
    if (mem) begin
      m = x + 1;
      for (int i = 0; i <= lrd; i++) e_lv[m+i] = 1;
      d_lrdy[m+lrd] = 1;
      wt = m + lrd + 1;
      if (lrsp != 0) begin
        d_lrv[wt+lrsp-1] = 1; d_lerr[wt+lrsp-1] = lerr;
      end
      if (lrsp == 0 || lrsp >= TO) begin
        trap_at(wt + TO, 3'd5); return;
      end
      wb = wt + lrsp;
      if (lerr) begin
        trap_at(wb, 3'd4); return;
      end
    end else begin
      wb = x + 1;
    end
    e_ret[wb] = 1;
    e_wen[wb] = wen && (rd != 5'd0);
    adv(wb + 1);
    mpc = npc; mret = mret + 64'd1;
    cur = wb + 1; endc = cur + 3;
  endtask

  task automatic fin();
    adv(MAXC);
    if (!trapped) for (int c = cur; c < MAXC; c++) e_iv[c] = 1;
  endtask

  task automatic run(input int n);
    rst = 1;
    ifu_req_ready = 0; lsu_req_ready = 0;
    ifu_resp_valid = 1; ifu_resp_err = 1;
    lsu_resp_valid = 1; lsu_resp_err = 1;
    @(posedge clk); #1;
    rst = 0;
    first_ret = -1; first_trap = -1;
    chk_en = 1;
    for (int c = 0; c < n; c++) begin
      cc = c;
      ifu_req_ready = d_irdy[c]; ifu_resp_valid = d_irv[c];
      ifu_resp_err = d_ierr[c]; ifu_resp_inst = d_word[c];
      dec_mem = d_mem[c]; dec_rd_wen = d_wen[c]; dec_rd = d_rd[c];
      dec_illegal = d_ill[c]; exu_next_pc = d_npc[c];
      lsu_req_ready = d_lrdy[c]; lsu_resp_valid = d_lrv[c];
      lsu_resp_err = d_lerr[c];
      @(posedge clk); #1;
    end
    chk_en = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0; cc = 0;
    rst = 1; ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_err = 0;
    ifu_resp_inst = '0; dec_mem = 0; dec_rd_wen = 0; dec_rd = '0;
    dec_illegal = 0; exu_next_pc = '0; lsu_req_ready = 0;
    lsu_resp_valid = 0; lsu_resp_err = 0;
    repeat (2) @(posedge clk);
    #1;

    // nop, addi x5 with delays, write to x0
    clr();
    add_inst(0, 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 0, 0);
    add_inst(2, 3, 32'h0050_0293, 0, 0, 0, 1, 5'd5, RPC + 8, 0, 0, 0);
    add_inst(0, 1, 32'h0010_0013, 0, 0, 0, 1, 5'd0, RPC + 12, 0, 0, 0);
    fin(); run(endc);
    chk("pin_first_ret", 64'(first_ret), 64'd3);
    chk("pin_pc", 64'(pc), 64'h8000_000C);
    chk("pin_instret", instret_cnt, 64'd3);

    // load with slow LSU, store, then jump
    clr();
    add_inst(0, 1, 32'h0005_2503, 1, 3, 2, 1, 5'd10, RPC + 4, 0, 0, 0);
    add_inst(1, 2, 32'h00a5_2223, 1, 0, 1, 0, 5'd0, RPC + 32'h100, 0, 0, 0);
    add_inst(0, 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 32'h104, 0, 0, 0);
    fin(); run(endc);
    chk("pin_load_ret", 64'(first_ret), 64'd9);
    chk("pin_jump_pc", 64'(pc), 64'h8000_0104);

    // misaligned next pc
    clr();
    add_inst(0, 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 2, 0, 0, 0);
    fin(); run(endc);
    chk("pin_misalign_cause", 64'(trap_cause), 64'd2);
    chk("pin_misalign_pc", 64'(pc), 64'h8000_0000);
    chk("pin_misalign_ret", instret_cnt, 64'd0);

    // illegal beats misaligned
    clr();
    add_inst(0, 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 0, 0);
    add_inst(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd3, RPC + 6, 1, 0, 0);
    fin(); run(endc);
    chk("pin_illegal_cause", 64'(trap_cause), 64'd1);

    // IFU bus error
    clr();
    add_inst(1, 2, 32'h0000_1234, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 1, 0);
    fin(); run(endc);
    chk("pin_ifu_err_inst", 64'(inst), 64'(NOP));

    // LSU bus error
    clr();
    add_inst(0, 1, 32'h0005_2383, 1, 0, 3, 1, 5'd7, RPC + 4, 0, 0, 1);
    fin(); run(endc);
    chk("pin_lsu_err_cause", 64'(trap_cause), 64'd4);

    // fetch never answered
    clr();
    add_inst(0, 0, NOP, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 0, 0);
    fin(); run(endc);
    chk("pin_timeout_at", 64'(first_trap), 64'd9);
    chk("pin_timeout_cause", 64'(trap_cause), 64'd5);

    // fetch answered one cycle before expiry; load answered on expiry
    clr();
    add_inst(0, TO - 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 0, 0);
    add_inst(0, 1, 32'h0005_2503, 1, 1, TO, 1, 5'd10, RPC + 8, 0, 0, 0);
    fin(); run(endc);
    chk("pin_mem_timeout_ret", instret_cnt, 64'd1);

    // abandon a load in MEM_WAIT
    clr();
    add_inst(0, 1, 32'h0005_2503, 1, 0, 0, 1, 5'd10, RPC + 4, 0, 0, 0);
    fin(); run(6);

    // stale responses after reset are ignored
    clr();
    add_inst(2, 1, NOP, 0, 0, 0, 0, 5'd0, RPC + 4, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      d_lrv[c] = 1; d_lerr[c] = 1;
    end
    for (int c = 0; c < 2; c++) begin
      d_irv[c] = 1; d_ierr[c] = 1;
    end
    fin(); run(endc);
    chk("pin_resume_ret", instret_cnt, 64'd1);
    chk("pin_resume_pc", 64'(pc), 64'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
